store_buffer: RTL and testbench

- FIFO store buffer between the MEM pipeline stage and data_mem.
- Absorbs 64-bit doubleword stores from the pipeline and drains them into data_mem one per cycle, whenever the single memory port is not needed by a load.
- Forwards buffered store data to exact-address loads and flags partially overlapping loads so the hazard unit can stall.
- Drives data_mem's adr/d_in/mrd/mwr and consumes its d_out.

---
 rtl/store_buffer_if.sv | 34 +++
 rtl/store_buffer.sv | 138 +++++++++++++
 tb/tb_store_buffer.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/store_buffer_if.sv
// Bundle of the pipeline-side store/load signals and the data_mem port signals
// seen by the store buffer.
interface store_buffer_if #(
    parameter int AW = 64,
    parameter int DW = 64
);
    logic          st_valid;
    logic [AW-1:0] st_adr;
    logic [DW-1:0] st_data;
    logic          st_ready;
    logic          ld_req;
    logic [AW-1:0] ld_adr;
    logic [DW-1:0] ld_data;
    logic          ld_hit;
    logic          ld_conflict;
    logic          empty;
    logic [AW-1:0] mem_adr;
    logic [DW-1:0] mem_din;
    logic          mem_rd;
    logic          mem_wr;
    logic [DW-1:0] mem_dout;

    modport slave (
        input  st_valid, st_adr, st_data, ld_req, ld_adr, mem_dout,
        output st_ready, ld_data, ld_hit, ld_conflict, empty,
               mem_adr, mem_din, mem_rd, mem_wr
    );

    modport master (
        output st_valid, st_adr, st_data, ld_req, ld_adr, mem_dout,
        input  st_ready, ld_data, ld_hit, ld_conflict, empty,
               mem_adr, mem_din, mem_rd, mem_wr
    );
endinterface

// File: rtl/store_buffer.sv
// FIFO store buffer between MEM and data_mem: queues doubleword stores, drains
// them when the memory port is free, forwards to exact-address loads.
module store_buffer #(
    parameter int DEPTH = 4,
    parameter int AW    = 64,
    parameter int DW    = 64
) (
    input  logic           clk,
    input  logic           rst_n,
    store_buffer_if.slave  sb
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);
    localparam logic [AW:0] DW_BYTES = (AW+1)'(4'd8);

    typedef enum logic [1:0] {
        MODE_IDLE  = 2'd0,
        MODE_LOAD  = 2'd1,
        MODE_DRAIN = 2'd2
    } mode_e;

    logic [AW-1:0] adr_r  [DEPTH];
    logic [DW-1:0] data_r [DEPTH];
    logic [PW-1:0] head_r;
    logic [PW-1:0] tail_r;
    logic [PW:0]   count_r;

    logic          enq_s;
    logic          drain_s;
    logic          hit_s;
    logic          overlap_s;
    logic          conflict_s;
    logic [DW-1:0] fwd_data_s;
    mode_e         mode_s;

    // Scan valid entries oldest to youngest so the youngest exact match wins.
    always_comb begin
        logic [PW-1:0] idx_v;
        logic          valid_v;
        logic          exact_v;
        logic          ovl_v;
        logic [AW:0]   ea_v;
        logic [AW:0]   la_v;
        hit_s      = 1'b0;
        overlap_s  = 1'b0;
        fwd_data_s = '0;
        la_v       = {1'b0, sb.ld_adr};
        for (int k = 0; k < DEPTH; k++) begin
            idx_v      = head_r + PW'(k);
            valid_v    = ((PW+1)'(k) < count_r);
            ea_v       = {1'b0, adr_r[idx_v]};
            exact_v    = valid_v && (adr_r[idx_v] == sb.ld_adr);
            ovl_v      = valid_v && (ea_v < la_v + DW_BYTES) && (la_v < ea_v + DW_BYTES);
            overlap_s  = overlap_s | (ovl_v & ~exact_v);
            hit_s      = hit_s | exact_v;
            fwd_data_s = exact_v ? data_r[idx_v] : fwd_data_s;
        end
    end

    // Port arbitration: loads own the port unless they conflict with a buffered store.
    always_comb begin
        conflict_s = sb.ld_req & overlap_s;
        if (sb.ld_req && !conflict_s) begin
            mode_s = MODE_LOAD;
        end else if (count_r != '0) begin
            mode_s = MODE_DRAIN;
        end else begin
            mode_s = MODE_IDLE;
        end
        enq_s   = rst_n & sb.st_valid & (count_r != FULL_CNT);
        drain_s = rst_n & (mode_s == MODE_DRAIN);
    end

    // Output drive; everything is forced to its idle value while reset is asserted.
    always_comb begin
        sb.st_ready    = 1'b1;
        sb.empty       = 1'b1;
        sb.ld_data     = '0;
        sb.ld_hit      = 1'b0;
        sb.ld_conflict = 1'b0;
        sb.mem_adr     = '0;
        sb.mem_din     = '0;
        sb.mem_rd      = 1'b0;
        sb.mem_wr      = 1'b0;
        if (rst_n) begin
            sb.st_ready    = (count_r != FULL_CNT);
            sb.empty       = (count_r == '0);
            sb.ld_conflict = conflict_s;
            case (mode_s)
                MODE_LOAD: begin
                    // A forwarded load does not need the memory read.
                    sb.mem_rd  = ~hit_s;
                    sb.mem_adr = sb.ld_adr;
                    sb.mem_din = (count_r != '0) ? data_r[head_r] : '0;
                    sb.ld_hit  = hit_s;
                    sb.ld_data = hit_s ? fwd_data_s : sb.mem_dout;
                end
                MODE_DRAIN: begin
                    sb.mem_wr  = 1'b1;
                    sb.mem_adr = adr_r[head_r];
                    sb.mem_din = data_r[head_r];
                end
                default: begin
                    sb.mem_adr = '0;
                end
            endcase
        end else begin
            sb.st_ready = 1'b1;
        end
    end

    // Queue state: enqueue at tail, drain at head, occupancy count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_r  <= '0;
            tail_r  <= '0;
            count_r <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                adr_r[i]  <= '0;
                data_r[i] <= '0;
            end
        end else begin
            if (enq_s) begin
                adr_r[tail_r]  <= sb.st_adr;
                data_r[tail_r] <= sb.st_data;
                tail_r         <= tail_r + PW'(1);
            end
            if (drain_s) begin
                head_r <= head_r + PW'(1);
            end
            case ({enq_s, drain_s})
                2'b10:   count_r <= count_r + (PW+1)'(1);
                2'b01:   count_r <= count_r - (PW+1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end
endmodule

// File: tb/tb_store_buffer.sv
// Directed table-driven bench for store_buffer plus hand-written reset sequences.
module tb_store_buffer;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    store_buffer_if #(.AW(64), .DW(64)) sb();

    store_buffer #(.DEPTH(4), .AW(64), .DW(64)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .sb    (sb.master)
    );

    typedef struct {
        logic        sv;
        logic [63:0] sa;
        logic [63:0] sd;
        logic        lr;
        logic [63:0] la;
        logic [63:0] md;
        logic [5:0]  flags;   // {st_ready, empty, mem_wr, mem_rd, ld_hit, ld_conflict}
        logic [63:0] madr;
        logic [63:0] mdin;
        logic [63:0] ldata;
    } vec_t;

    localparam logic [63:0] Z    = 64'd0;
    localparam logic [63:0] G    = 64'h1122_3344_5566_7788;
    localparam logic [63:0] H    = 64'h0123_4567_89AB_CDEF;
    localparam logic [63:0] A    = 64'hAAAA_AAAA_AAAA_AAAA;
    localparam logic [63:0] B    = 64'hBBBB_BBBB_BBBB_BBBB;
    localparam logic [63:0] C    = 64'hCCCC_CCCC_CCCC_CCCC;
    localparam logic [63:0] E    = 64'hEEEE_EEEE_EEEE_EEEE;
    localparam logic [63:0] F    = 64'hFFFF_0000_FFFF_0000;
    localparam logic [63:0] D1   = 64'hD1D1_D1D1_D1D1_D1D1;
    localparam logic [63:0] D2   = 64'hD2D2_D2D2_D2D2_D2D2;
    localparam logic [63:0] D3   = 64'hD3D3_D3D3_D3D3_D3D3;
    localparam logic [63:0] S0   = 64'h10;
    localparam logic [63:0] S1   = 64'h11;
    localparam logic [63:0] S2   = 64'h12;
    localparam logic [63:0] S3   = 64'h13;
    localparam logic [63:0] S4   = 64'h14;
    localparam logic [63:0] TOPC = 64'hFFFF_FFFF_FFFF_FFFC;
    localparam logic [63:0] TOP8 = 64'hFFFF_FFFF_FFFF_FFF8;

    int n_cmp = 0;
    int n_bad = 0;
    vec_t tbl[$];

    function automatic vec_t mk(input logic sv, input logic [63:0] sa, input logic [63:0] sd,
                                input logic lr, input logic [63:0] la, input logic [63:0] md,
                                input logic [5:0] flags, input logic [63:0] madr,
                                input logic [63:0] mdin, input logic [63:0] ldata);
        vec_t v;
        v.sv = sv; v.sa = sa; v.sd = sd; v.lr = lr; v.la = la; v.md = md;
        v.flags = flags; v.madr = madr; v.mdin = mdin; v.ldata = ldata;
        return v;
    endfunction

    function automatic logic [197:0] outs();
        return {sb.st_ready, sb.empty, sb.mem_wr, sb.mem_rd, sb.ld_hit, sb.ld_conflict,
                sb.mem_adr, sb.mem_din, sb.ld_data};
    endfunction

    task automatic drive(input logic sv, input logic [63:0] sa, input logic [63:0] sd,
                         input logic lr, input logic [63:0] la, input logic [63:0] md);
        sb.st_valid = sv; sb.st_adr = sa; sb.st_data = sd;
        sb.ld_req = lr; sb.ld_adr = la; sb.mem_dout = md;
    endtask

    task automatic check(input string name, input logic [5:0] flags, input logic [63:0] madr,
                         input logic [63:0] mdin, input logic [63:0] ldata);
        logic [197:0] act;
        logic [197:0] exp;
        act = outs();
        exp = {flags, madr, mdin, ldata};
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got flags=%b adr=%h din=%h ld=%h, expected flags=%b adr=%h din=%h ld=%h",
                     name, act[197:192], act[191:128], act[127:64], act[63:0],
                     flags, madr, mdin, ldata);
        end
    endtask

    initial begin
        // single store then drain
        tbl.push_back(mk(1'b0, Z, Z, 1'b0, Z, Z, 6'b110000, Z, Z, Z));
        tbl.push_back(mk(1'b1, 64'd2000, G, 1'b0, Z, Z, 6'b110000, Z, Z, Z));
        tbl.push_back(mk(1'b0, Z, Z, 1'b0, Z, Z, 6'b101000, 64'd2000, G, Z));
        tbl.push_back(mk(1'b0, Z, Z, 1'b0, Z, Z, 6'b110000, Z, Z, Z));
        // fill while loads hold the port, fifth store held, then drain with enqueue
        tbl.push_back(mk(1'b1, 64'd1000, S0, 1'b1, 64'd5000, D1, 6'b110100, 64'd5000, Z, D1));
        tbl.push_back(mk(1'b1, 64'd1008, S1, 1'b1, 64'd5000, D1, 6'b100100, 64'd5000, S0, D1));
        tbl.push_back(mk(1'b1, 64'd1016, S2, 1'b1, 64'd5000, D1, 6'b100100, 64'd5000, S0, D1));
        tbl.push_back(mk(1'b1, 64'd1024, S3, 1'b1, 64'd5000, D1, 6'b100100, 64'd5000, S0, D1));
        tbl.push_back(mk(1'b1, 64'd1032, S4, 1'b1, 64'd5000, D1, 6'b000100, 64'd5000, S0, D1));
        tbl.push_back(mk(1'b1, 64'd1032, S4, 1'b0, Z, Z, 6'b001000, 64'd1000, S0, Z));
        tbl.push_back(mk(1'b1, 64'd1032, S4, 1'b0, Z, Z, 6'b101000, 64'd1008, S1, Z));
        tbl.push_back(mk(1'b0, Z, Z, 1'b0, Z, Z, 6'b101000, 64'd1016, S2, Z));
        tbl.push_back(mk(1'b0, Z, Z, 1'b0, Z, Z, 6'b101000, 64'd1024, S3, Z));
        tbl.push_back(mk(1'b0, Z, Z, 1'b0, Z, Z, 6'b101000, 64'd1032, S4, Z));
        tbl.push_back(mk(1'b0, Z, Z, 1'b0, Z, Z, 6'b110000, Z, Z, Z));
        // forwarding: same-cycle store invisible, youngest wins, miss reads memory
        tbl.push_back(mk(1'b1, 64'd1500, A, 1'b0, Z, Z, 6'b110000, Z, Z, Z));
        tbl.push_back(mk(1'b1, 64'd1500, B, 1'b1, 64'd1500, D2, 6'b100010, 64'd1500, A, A));
        tbl.push_back(mk(1'b0, Z, Z, 1'b1, 64'd1500, D2, 6'b100010, 64'd1500, A, B));
        tbl.push_back(mk(1'b0, Z, Z, 1'b1, 64'd1600, D2, 6'b100100, 64'd1600, A, D2));
        tbl.push_back(mk(1'b0, Z, Z, 1'b0, Z, Z, 6'b101000, 64'd1500, A, Z));
        tbl.push_back(mk(1'b0, Z, Z, 1'b0, Z, Z, 6'b101000, 64'd1500, B, Z));
        // partial overlap forces a drain, then the load proceeds
        tbl.push_back(mk(1'b1, 64'd2000, C, 1'b0, Z, Z, 6'b110000, Z, Z, Z));
        tbl.push_back(mk(1'b0, Z, Z, 1'b1, 64'd2004, D3, 6'b101001, 64'd2000, C, Z));
        tbl.push_back(mk(1'b0, Z, Z, 1'b1, 64'd2004, D3, 6'b110100, 64'd2004, Z, D3));
        // conflict beats an exact hit on another entry
        tbl.push_back(mk(1'b1, 64'd3000, E, 1'b0, Z, Z, 6'b110000, Z, Z, Z));
        tbl.push_back(mk(1'b1, 64'd3004, F, 1'b1, 64'd5000, D1, 6'b100100, 64'd5000, E, D1));
        tbl.push_back(mk(1'b0, Z, Z, 1'b1, 64'd3000, D1, 6'b101001, 64'd3000, E, Z));
        tbl.push_back(mk(1'b0, Z, Z, 1'b1, 64'd3000, D1, 6'b101001, 64'd3004, F, Z));
        tbl.push_back(mk(1'b0, Z, Z, 1'b1, 64'd3000, D1, 6'b110100, 64'd3000, Z, D1));
        // top of address space: no wrap-around overlap with address 0
        tbl.push_back(mk(1'b1, TOPC, H, 1'b1, Z, D2, 6'b110100, Z, Z, D2));
        tbl.push_back(mk(1'b0, Z, Z, 1'b1, Z, D2, 6'b100100, Z, H, D2));
        tbl.push_back(mk(1'b0, Z, Z, 1'b1, TOP8, D2, 6'b101001, TOPC, H, Z));
        tbl.push_back(mk(1'b0, Z, Z, 1'b0, Z, Z, 6'b110000, Z, Z, Z));

        drive(1'b1, 64'd2000, G, 1'b1, 64'd5000, D1);
        #2;
        check("in_reset", 6'b110000, Z, Z, Z);
        @(negedge clk);
        drive(1'b0, Z, Z, 1'b0, Z, Z);
        rst_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            drive(tbl[i].sv, tbl[i].sa, tbl[i].sd, tbl[i].lr, tbl[i].la, tbl[i].md);
            #1;
            check($sformatf("row%0d", i), tbl[i].flags, tbl[i].madr, tbl[i].mdin, tbl[i].ldata);
        end

        // async reset in the middle of draining three stores
        @(negedge clk); drive(1'b1, 64'd4000, S0, 1'b1, 64'd5000, D1);
        @(negedge clk); drive(1'b1, 64'd4008, S1, 1'b1, 64'd5000, D1);
        @(negedge clk); drive(1'b1, 64'd4016, S2, 1'b1, 64'd5000, D1);
        @(negedge clk); drive(1'b0, Z, Z, 1'b0, Z, Z);
        #1;
        check("pre_reset_drain", 6'b101000, 64'd4000, S0, Z);
        #1;
        rst_n = 1'b0;
        drive(1'b0, Z, Z, 1'b1, 64'd5000, D1);
        #1;
        check("async_reset", 6'b110000, Z, Z, Z);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b0, Z, Z, 1'b0, Z, Z);
        #1;
        check("post_reset", 6'b110000, Z, Z, Z);
        @(negedge clk);
        #1;
        check("post_reset_quiet", 6'b110000, Z, Z, Z);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
